// File: rtl/exp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exp_pkg
// Purpose : Shared types and helpers for the sequential exponentiation unit.
//           Holds the controller state encoding and the index-width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package exp_pkg;

  // Controller states of the square-and-multiply sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } exp_state_t;

  // Bits needed to hold an exponent bit index; never less than one bit so a
  // single-bit exponent still has a legal register.
  function automatic int idx_width(input int exp_width);
    return (exp_width > 1) ? $clog2(exp_width) : 1;
  endfunction

endpackage : exp_pkg
`default_nettype wire

// File: rtl/exp_mul.sv
`default_nettype none
// ============================================================================
// Module  : exp_mul
// Purpose : Combinational unsigned WIDTH x WIDTH multiplier. Returns the low
//           half of the full product and a flag for a non-zero upper half.
// Ports   : a, b   - unsigned operands (WIDTH)
//           lo     - low WIDTH bits of a*b
//           hi_nz  - 1 when the upper WIDTH bits of a*b are non-zero
// Rev     : 1.0  initial release
// ============================================================================
module exp_mul #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] prod;

  // Zero-extend both operands so the product is evaluated at full width.
  assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign lo    = prod[WIDTH-1:0];
  assign hi_nz = |prod[2*WIDTH-1:WIDTH];

endmodule : exp_mul
`default_nettype wire

// File: rtl/exp_seq.sv
`default_nettype none
// ============================================================================
// Module  : exp_seq
// Purpose : Sequential integer exponentiation, base ** exp, using
//           left-to-right square-and-multiply with one multiply per clock.
//           Valid/ready on both sides, exact overflow flag, optional
//           saturation of the result to all-ones on overflow.
// Ports   : clk, rst_n            - clock, async active-low reset
//           in_valid/in_ready     - operand handshake
//           base (WIDTH)          - base operand
//           exp  (EXP_WIDTH)      - unsigned exponent
//           out_valid/out_ready   - result handshake
//           result (WIDTH)        - base**exp truncated or saturated
//           overflow              - true result >= 2**WIDTH
//           busy                  - computation in progress
// Rev     : 1.0  initial release
// ============================================================================
module exp_seq
  import exp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow,
  output logic                 busy
);

  localparam int                IDX_W   = idx_width(EXP_WIDTH);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(EXP_WIDTH - 1);

  exp_state_t           state_q, state_d;
  logic [WIDTH-1:0]     base_q,  base_d;
  logic [EXP_WIDTH-1:0] exp_q,   exp_d;
  logic [WIDTH-1:0]     acc_q,   acc_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 ovf_q,   ovf_d;

  logic [WIDTH-1:0]     mul_b;
  logic [WIDTH-1:0]     mul_lo;
  logic                 mul_hi_nz;

  // One shared multiplier: squares acc in SQR, multiplies by the captured
  // base in MUL. Outside those states its output is simply not used.
  assign mul_b = (state_q == MUL) ? base_q : acc_q;

  exp_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a     (acc_q),
    .b     (mul_b),
    .lo    (mul_lo),
    .hi_nz (mul_hi_nz)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d  = base;
          exp_d   = exp;
          acc_d   = WIDTH'(1);
          idx_d   = IDX_TOP;
          ovf_d   = 1'b0;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = mul_lo;
        ovf_d = ovf_q | mul_hi_nz;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MUL: begin
        acc_d = mul_lo;
        ovf_d = ovf_q | mul_hi_nz;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      exp_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SQR) || (state_q == MUL);
  assign overflow  = ovf_q;
  // Driven purely from registers, so there is no input-to-output path.
  assign result    = (SATURATE && ovf_q) ? {WIDTH{1'b1}} : acc_q;

endmodule : exp_seq
`default_nettype wire
